ram_share_ctrl: RTL and testbench
=================================

// Module: ram_share_ctrl
// PURPOSE
//  Shares the single-port program/data RAM between the accumulator core and an external host (UART loader/debugger).
//  Halts the core through a clock enable, drains it and grants the RAM to the host.
//  Returns the RAM to the core with a guaranteed minimum run quantum, and optionally restarts the core from PC=0.
// PARAMETERS
//  word_width    8   RAM word / core accumulator width
//  addr_width    3   RAM address width ($clog2(word_width) in the core)
//  core_quantum  16  min core_en cycles after a host session before the next grant (0 = no guarantee)
// PORTS
//  clk          in   1           system clock, all logic on posedge
//  reset_n      in   1           asynchronous, active-low reset
//  host_req     in   1           host wants the RAM; level, held for the whole session
//  host_gnt     out  1           host owns the RAM (state HOST)
//  host_valid   in   1           one access per cycle, accepted when host_req & host_gnt
//  host_we      in   1           1 = write, 0 = read (qualified by host_valid)
//  host_addr    in   addr_width  host access address
//  host_wdata   in   word_width  host write data
//  host_ack     out  1           registered; pulses 1 cycle after each accepted access
//  host_rdata   out  word_width  read data, valid with host_ack (reads only)
//  host_restart in   1           sampled in RELEASE; 1 = pulse core_rst
//  core_en      out  1           core clock enable (core state/PC/A frozen when 0)
//  core_rst     out  1           1-cycle sync reset pulse to core (core's active-high reset)
//  core_write   in   1           core write strobe
//  core_addr    in   addr_width  core write/operand address
//  core_wdata   in   word_width  core write data (A)
//  ram_we       out  1           RAM write enable
//  ram_addr     out  addr_width  RAM address (write / operand read port)
//  ram_wdata    out  word_width  RAM write data
//  ram_rdata    in   word_width  RAM read data, 1-cycle read latency
// BEHAVIOUR
//  One clock domain. Reset is asynchronous, active-low, and all outputs are registered or decoded from state.
//  Reset values: state RUN, quantum counter 0, host_gnt 0, host_ack 0, host_rdata 0, core_rst 0.
//   core_en is decoded from state, so it is 1 out of reset; ram_* follow the core mux.
//  FSM states: RUN, DRAIN, HOST, RELEASE.
//   RUN: core_en=1. RAM mux selects the core: ram_we=core_write, ram_addr=core_addr, ram_wdata=core_wdata.
//    Quantum counter decrements to 0 and saturates there.
//    host_req & counter==0 -> DRAIN. If counter!=0, host_req waits; the request is not dropped.
//   DRAIN (exactly 1 cycle): core_en=0 and ram_we=0 (a core write strobe in this cycle is masked). -> HOST.
//   HOST: core_en=0, host_gnt=1. RAM mux selects the host.
//    ram_we = host_valid & host_we & host_req.
//    Accepted access -> host_ack=1 next cycle; for reads, host_rdata=ram_rdata.
//    Back-to-back accesses are allowed every cycle. The core write strobe is ignored.
//    host_req=0 -> RELEASE. host_valid in that same cycle is NOT accepted (no ack, no write).
//   RELEASE (exactly 1 cycle): core_en=0, host_gnt=0, ram_we=0. The ack of the last HOST access is still issued here.
//    host_restart=1 -> core_rst=1 this cycle (core PC returns to 0 on its next enabled edge).
//    Load quantum counter with core_quantum. -> RUN.
//  Latency: host_req rise in RUN with counter 0 -> host_gnt=1 two cycles later (DRAIN, then HOST).
//  Simultaneous events:
//   - host_req drops in DRAIN: still enter HOST, then immediately RELEASE.
//   - host_req=1 in RELEASE: next grant waits for the quantum.
//  Reset mid-session (any state): immediate return to RUN, host_gnt=0, pending ack discarded.
//  Counter width: $clog2(core_quantum+1), minimum 1 bit.
// TESTING
//  1. Reset release, host_req=0: core_en=1, ram_we follows core_write, host_gnt=0 for 50 cycles.
//  2. host_req=1 at cycle t, counter 0: core_en=0 at t+1, host_gnt=1 at t+2.
//     Write 8'hA5 @3, then read @3 -> host_ack 1 cycle after each access, host_rdata=8'hA5.
//  3. core_write=1 held during DRAIN/HOST -> ram_we never set from core; RAM @core_addr unchanged.
//  4. Session ends, then host_req re-asserted immediately (core_quantum=16)
//     -> core_en=1 for exactly 16 cycles before the next DRAIN.
//  5. host_restart=1 at release -> core_rst pulses 1 cycle in RELEASE; core fetches from PC 0.
//  6. reset_n low during HOST with a read in flight -> host_gnt=0 and host_ack=0 asynchronously; RUN after release.

Source files
------------

// File: rtl/ram_share_ctrl.sv
// Arbitrates the single-port program/data RAM between the accumulator core and an external host.
// The core is halted via core_en, drained for one cycle, and then the RAM is granted to the host.
module ram_share_ctrl #(
    parameter int word_width   = 8,
    parameter int addr_width   = 3,
    parameter int core_quantum = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  host_req,
    output logic                  host_gnt,
    input  logic                  host_valid,
    input  logic                  host_we,
    input  logic [addr_width-1:0] host_addr,
    input  logic [word_width-1:0] host_wdata,
    output logic                  host_ack,
    output logic [word_width-1:0] host_rdata,
    input  logic                  host_restart,
    output logic                  core_en,
    output logic                  core_rst,
    input  logic                  core_write,
    input  logic [addr_width-1:0] core_addr,
    input  logic [word_width-1:0] core_wdata,
    output logic                  ram_we,
    output logic [addr_width-1:0] ram_addr,
    output logic [word_width-1:0] ram_wdata,
    input  logic [word_width-1:0] ram_rdata
);

    localparam int CW = (core_quantum < 1) ? 1 : $clog2(core_quantum + 1);
    localparam logic [CW-1:0] QLOAD = CW'(core_quantum);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_DRAIN,
        ST_HOST,
        ST_RELEASE
    } state_t;

    state_t                r_state;
    logic [CW-1:0]         r_quota;
    logic                  r_gnt;
    logic                  r_ack;
    logic                  r_ack_rd;
    logic [word_width-1:0] r_rdata;

    logic                  w_accept;
    logic [CW-1:0]         w_quota_dec;
    logic                  w_quota_done;

    assign w_accept    = (r_state == ST_HOST) & host_valid & host_req;
    assign w_quota_dec = (r_quota == '0) ? '0 : r_quota - CW'(1);
    // Grant on the edge that retires the last quantum cycle, so the core gets exactly core_quantum enables.
    assign w_quota_done = (w_quota_dec == '0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= ST_RUN;
            r_quota  <= '0;
            r_gnt    <= 1'b0;
            r_ack    <= 1'b0;
            r_ack_rd <= 1'b0;
            r_rdata  <= '0;
        end else begin
            r_ack    <= w_accept;
            r_ack_rd <= w_accept & ~host_we;
            if (r_ack_rd) begin
                r_rdata <= ram_rdata;
            end
            case (r_state)
                ST_RUN: begin
                    r_quota <= w_quota_dec;
                    if (host_req && w_quota_done) begin
                        r_state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    r_state <= ST_HOST;
                    r_gnt   <= 1'b1;
                end
                ST_HOST: begin
                    if (!host_req) begin
                        r_state <= ST_RELEASE;
                        r_gnt   <= 1'b0;
                    end
                end
                ST_RELEASE: begin
                    r_quota <= QLOAD;
                    r_state <= ST_RUN;
                end
                default: begin
                    r_state <= ST_RUN;
                    r_gnt   <= 1'b0;
                end
            endcase
        end
    end

    assign host_gnt = r_gnt;
    assign host_ack = r_ack;
    // RAM read data arrives in the ack cycle; hold it afterwards so host_rdata stays stable.
    assign host_rdata = r_ack_rd ? ram_rdata : r_rdata;
    assign core_en    = (r_state == ST_RUN);
    assign core_rst   = (r_state == ST_RELEASE) & host_restart;

    always_comb begin
        ram_we    = 1'b0;
        ram_addr  = core_addr;
        ram_wdata = core_wdata;
        case (r_state)
            ST_RUN: begin
                ram_we = core_write;
            end
            ST_HOST: begin
                ram_we    = host_valid & host_we & host_req;
                ram_addr  = host_addr;
                ram_wdata = host_wdata;
            end
            default: begin
                ram_we = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_ram_share_ctrl.sv
// Bench for ram_share_ctrl: directed vector table, hand sequences for quantum/reset corners,
// and randomized traffic checked against a session-level reference model.
module tb_ram_share_ctrl;

    localparam int W = 8;
    localparam int A = 3;
    localparam int Q = 16;

    logic         clk          = 1'b0;
    logic         reset_n      = 1'b0;
    logic         host_req     = 1'b0;
    logic         host_valid   = 1'b0;
    logic         host_we      = 1'b0;
    logic [A-1:0] host_addr    = '0;
    logic [W-1:0] host_wdata   = '0;
    logic         host_restart = 1'b0;
    logic         core_write   = 1'b0;
    logic [A-1:0] core_addr    = '0;
    logic [W-1:0] core_wdata   = '0;

    logic         host_gnt;
    logic         host_ack;
    logic [W-1:0] host_rdata;
    logic         core_en;
    logic         core_rst;
    logic         ram_we;
    logic [A-1:0] ram_addr;
    logic [W-1:0] ram_wdata;

    logic [W-1:0] mem [8] = '{default: '0};
    logic [W-1:0] ram_rdata = '0;

    ram_share_ctrl #(
        .word_width  (W),
        .addr_width  (A),
        .core_quantum(Q)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .host_req    (host_req),
        .host_gnt    (host_gnt),
        .host_valid  (host_valid),
        .host_we     (host_we),
        .host_addr   (host_addr),
        .host_wdata  (host_wdata),
        .host_ack    (host_ack),
        .host_rdata  (host_rdata),
        .host_restart(host_restart),
        .core_en     (core_en),
        .core_rst    (core_rst),
        .core_write  (core_write),
        .core_addr   (core_addr),
        .core_wdata  (core_wdata),
        .ram_we      (ram_we),
        .ram_addr    (ram_addr),
        .ram_wdata   (ram_wdata),
        .ram_rdata   (ram_rdata)
    );

    always #5 clk = ~clk;

    // Synchronous single-port RAM, one cycle read latency.
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: who owns the RAM, and how many core cycles have elapsed since the last session.
    bit           m_drain, m_host, m_rel;
    int           m_ran;
    bit           m_ack, m_ack_rd;
    logic [W-1:0] m_rdata;
    logic [W-1:0] ref_mem [8];

    task automatic model_step();
        if (m_rel) begin
            m_rel = 0;
            m_ran = 0;
            m_ack = 0;
        end else if (m_drain) begin
            m_drain = 0;
            m_host  = 1;
            m_ack   = 0;
        end else if (m_host) begin
            m_ack    = host_valid && host_req;
            m_ack_rd = m_ack && !host_we;
            if (m_ack) begin
                if (host_we) ref_mem[host_addr] = host_wdata;
                else         m_rdata = ref_mem[host_addr];
            end
            if (!host_req) begin
                m_host = 0;
                m_rel  = 1;
            end
        end else begin
            m_ack = 0;
            if (core_write) ref_mem[core_addr] = core_wdata;
            if (m_ran < 1000) m_ran++;
            if (host_req && m_ran >= Q) m_drain = 1;
        end
    endtask

    task automatic check_outputs();
        bit   run;
        logic exp_we;
        run = !(m_drain || m_host || m_rel);
        chk("core_en", 32'(core_en), 32'(run));
        chk("host_gnt", 32'(host_gnt), 32'(m_host));
        chk("core_rst", 32'(core_rst), 32'(m_rel && host_restart));
        exp_we = run ? core_write : (m_host ? (host_valid & host_we & host_req) : 1'b0);
        chk("ram_we", 32'(ram_we), 32'(exp_we));
        if (exp_we) begin
            chk("ram_addr", 32'(ram_addr), 32'(run ? core_addr : host_addr));
            chk("ram_wdata", 32'(ram_wdata), 32'(run ? core_wdata : host_wdata));
        end
        chk("host_ack", 32'(host_ack), 32'(m_ack));
        if (m_ack && m_ack_rd) chk("host_rdata", 32'(host_rdata), 32'(m_rdata));
    endtask

    task automatic wait_gnt(output bit ok);
        ok = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            #1;
            if (host_gnt) begin
                ok = 1;
                break;
            end
        end
    endtask

    typedef struct {
        logic         req, valid, we;
        logic [A-1:0] addr;
        logic [W-1:0] wdata;
        logic         restart, cw;
        logic         e_en, e_gnt, e_ack, e_we, e_rst;
        logic         chk_rd;
        logic [W-1:0] e_rdata;
    } vec_t;

    vec_t tbl[9];

    initial begin
        bit ok;
        int cnt;

        //         req   valid we    addr  wdata  rst   cw   | en    gnt   ack   we    crst  chkrd rdata
        tbl[0] = '{1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
        tbl[1] = '{1'b1, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
        tbl[2] = '{1'b1, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
        tbl[3] = '{1'b1, 1'b1, 1'b1, 3'd3, 8'hA5, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
        tbl[4] = '{1'b1, 1'b1, 1'b0, 3'd3, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
        tbl[5] = '{1'b1, 1'b1, 1'b1, 3'd5, 8'h5A, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'hA5};
        tbl[6] = '{1'b0, 1'b1, 1'b1, 3'd2, 8'h77, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
        tbl[7] = '{1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00};
        tbl[8] = '{1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};

        // Reset values
        repeat (3) @(negedge clk);
        #1;
        chk("rst_gnt", 32'(host_gnt), 32'd0);
        chk("rst_ack", 32'(host_ack), 32'd0);
        chk("rst_rdata", 32'(host_rdata), 32'd0);
        chk("rst_core_rst", 32'(core_rst), 32'd0);
        chk("rst_core_en", 32'(core_en), 32'd1);
        reset_n = 1'b1;

        // Idle core traffic with no host
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            core_write = 1'($urandom_range(0, 1));
            core_addr  = 3'd7;
            core_wdata = W'($urandom);
            #1;
            chk("idle_core_en", 32'(core_en), 32'd1);
            chk("idle_gnt", 32'(host_gnt), 32'd0);
            chk("idle_ram_we", 32'(ram_we), 32'(core_write));
        end

        // Directed session: grant latency, write/read, core masking, restart
        core_addr = 3'd6;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            host_req     = tbl[i].req;
            host_valid   = tbl[i].valid;
            host_we      = tbl[i].we;
            host_addr    = tbl[i].addr;
            host_wdata   = tbl[i].wdata;
            host_restart = tbl[i].restart;
            core_write   = tbl[i].cw;
            core_wdata   = (i < 2) ? 8'h11 : 8'h3C;
            #1;
            chk("tbl_core_en", 32'(core_en), 32'(tbl[i].e_en));
            chk("tbl_gnt", 32'(host_gnt), 32'(tbl[i].e_gnt));
            chk("tbl_ack", 32'(host_ack), 32'(tbl[i].e_ack));
            chk("tbl_ram_we", 32'(ram_we), 32'(tbl[i].e_we));
            chk("tbl_core_rst", 32'(core_rst), 32'(tbl[i].e_rst));
            if (tbl[i].chk_rd) chk("tbl_rdata", 32'(host_rdata), 32'(tbl[i].e_rdata));
        end
        chk("mem6_core_kept", 32'(mem[6]), 32'h11);
        chk("mem3_host", 32'(mem[3]), 32'hA5);
        chk("mem5_host", 32'(mem[5]), 32'h5A);
        chk("mem2_dropped", 32'(mem[2]), 32'h00);

        // Quantum: re-request during RELEASE, core must run exactly Q cycles
        host_req = 1'b1;
        wait_gnt(ok);
        chk("gnt_q_timeout", 32'(ok), 32'd1);
        host_req = 1'b0;
        @(negedge clk);
        #1;
        chk("rel_core_en", 32'(core_en), 32'd0);
        chk("rel_gnt", 32'(host_gnt), 32'd0);
        host_req = 1'b1;
        cnt = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            #1;
            if (core_en) cnt++;
            else break;
        end
        chk("quantum_len", 32'(cnt), 32'(Q));
        @(negedge clk);
        #1;
        chk("gnt_after_quantum", 32'(host_gnt), 32'd1);

        // Asynchronous reset with a read in flight
        host_valid = 1'b1;
        host_we    = 1'b0;
        host_addr  = 3'd3;
        @(posedge clk);
        #1;
        chk("ack_inflight", 32'(host_ack), 32'd1);
        host_valid = 1'b0;
        host_req   = 1'b0;
        reset_n    = 1'b0;
        #1;
        chk("arst_gnt", 32'(host_gnt), 32'd0);
        chk("arst_ack", 32'(host_ack), 32'd0);
        chk("arst_core_en", 32'(core_en), 32'd1);
        @(negedge clk);
        reset_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1;
            chk("post_rst_core_en", 32'(core_en), 32'd1);
            chk("post_rst_gnt", 32'(host_gnt), 32'd0);
        end

        // Randomized traffic against the reference model
        for (int a = 0; a < 8; a++) ref_mem[a] = mem[a];
        m_drain = 0;
        m_host  = 0;
        m_rel   = 0;
        m_ran   = 1000;
        m_ack   = 0;
        m_ack_rd = 0;
        m_rdata = '0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 9) == 0) host_req = ~host_req;
            host_valid   = 1'($urandom_range(0, 1));
            host_we      = 1'($urandom_range(0, 1));
            host_addr    = A'($urandom_range(0, 7));
            host_wdata   = W'($urandom);
            host_restart = 1'($urandom_range(0, 2) == 0);
            core_write   = 1'($urandom_range(0, 4) < 2);
            core_addr    = A'($urandom_range(0, 7));
            core_wdata   = W'($urandom);
            #1;
            check_outputs();
            @(posedge clk);
            model_step();
        end
        @(negedge clk);
        for (int a = 0; a < 8; a++) chk("rand_mem", 32'(mem[a]), 32'(ref_mem[a]));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
